// File: rtl/mem_stage.sv
// Memory pipeline stage: performs byte/word loads and stores over an 8-bit req/ack bus,
// stalling the pipeline while the bus is busy, then registers results for write-back.
module mem_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [32:0] control_signals_in,
    input  logic [15:0] pc_in,
    input  logic [15:0] imm_in,
    input  logic [15:0] addr_in,
    input  logic [15:0] wdata_in,
    input  logic        mem_read_b,
    input  logic        mem_read_w,
    input  logic        mem_write_b,
    input  logic        mem_write_w,
    output logic        bus_req,
    output logic        bus_we,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_ack,
    output logic        stall,
    output logic [15:0] rdata_out,
    output logic [32:0] control_signals_out,
    output logic [15:0] pc_out,
    output logic [15:0] imm_out
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [15:0] bus_addr_q, bus_addr_d;
    logic [7:0]  bus_wdata_q, bus_wdata_d;
    logic [7:0]  lo_byte_q, lo_byte_d;
    logic [7:0]  hi_byte_q, hi_byte_d;
    logic [15:0] rdata_q, rdata_d;
    logic [32:0] ctrl_q, ctrl_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] imm_q, imm_d;

    logic is_read, is_write, is_word, mem_op, acked, load;

    // Reads take priority over writes; within each class the word form wins.
    always_comb begin
        is_read  = mem_read_w | mem_read_b;
        is_write = ~is_read & (mem_write_w | mem_write_b);
        is_word  = mem_read_w | (~mem_read_b & mem_write_w);
        mem_op   = is_read | is_write;
        acked    = bus_req_q & bus_ack;
        stall    = ((state_q == IDLE) & en & mem_op) | (state_q == LO) | (state_q == HI);
        load     = en & ~stall;
    end

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        lo_byte_d   = lo_byte_q;
        hi_byte_d   = hi_byte_q;
        rdata_d     = rdata_q;
        ctrl_d      = ctrl_q;
        pc_d        = pc_q;
        imm_d       = imm_q;

        case (state_q)
            IDLE: begin
                if (en && mem_op) begin
                    state_d     = LO;
                    bus_req_d   = 1'b1;
                    bus_we_d    = is_write;
                    bus_addr_d  = addr_in;
                    bus_wdata_d = wdata_in[7:0];
                end
            end
            LO: begin
                if (acked) begin
                    if (is_read) lo_byte_d = bus_rdata;
                    if (is_word) begin
                        state_d     = HI;
                        bus_addr_d  = addr_in + 16'd1;
                        bus_wdata_d = wdata_in[15:8];
                    end else begin
                        state_d   = DONE;
                        bus_req_d = 1'b0;
                    end
                end
            end
            HI: begin
                if (acked) begin
                    if (is_read) hi_byte_d = bus_rdata;
                    state_d   = DONE;
                    bus_req_d = 1'b0;
                end
            end
            DONE: begin
                if (en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Byte loads zero-extend; stores and non-memory ops leave the load result alone.
        if (load) begin
            ctrl_d = control_signals_in;
            pc_d   = pc_in;
            imm_d  = imm_in;
            if (mem_read_w)      rdata_d = {hi_byte_q, lo_byte_q};
            else if (mem_read_b) rdata_d = {8'h00, lo_byte_q};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 16'h0000;
            bus_wdata_q <= 8'h00;
            lo_byte_q   <= 8'h00;
            hi_byte_q   <= 8'h00;
            rdata_q     <= 16'h0000;
            ctrl_q      <= 33'h0;
            pc_q        <= 16'h0000;
            imm_q       <= 16'h0000;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            lo_byte_q   <= lo_byte_d;
            hi_byte_q   <= hi_byte_d;
            rdata_q     <= rdata_d;
            ctrl_q      <= ctrl_d;
            pc_q        <= pc_d;
            imm_q       <= imm_d;
        end
    end

    assign bus_req             = bus_req_q;
    assign bus_we              = bus_we_q;
    assign bus_addr            = bus_addr_q;
    assign bus_wdata           = bus_wdata_q;
    assign rdata_out           = rdata_q;
    assign control_signals_out = ctrl_q;
    assign pc_out              = pc_q;
    assign imm_out             = imm_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: a byte-array memory answers the bus with random waits,
// and a transaction-level model predicts bus traffic, stall length and registered outputs.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [32:0] control_signals_in;
    logic [15:0] pc_in, imm_in, addr_in, wdata_in;
    logic        mem_read_b, mem_read_w, mem_write_b, mem_write_w;
    logic        bus_req, bus_we;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_ack;
    logic        stall;
    logic [15:0] rdata_out;
    logic [32:0] control_signals_out;
    logic [15:0] pc_out, imm_out;

    mem_stage dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .control_signals_in(control_signals_in), .pc_in(pc_in), .imm_in(imm_in),
        .addr_in(addr_in), .wdata_in(wdata_in),
        .mem_read_b(mem_read_b), .mem_read_w(mem_read_w),
        .mem_write_b(mem_write_b), .mem_write_w(mem_write_w),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .stall(stall),
        .rdata_out(rdata_out), .control_signals_out(control_signals_out),
        .pc_out(pc_out), .imm_out(imm_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } txn_t;

    txn_t        exp_q[$];
    logic [7:0]  mem [0:65535];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_rdata, exp_pc, exp_imm;
    logic [32:0] exp_ctrl;
    bit          cmp_en = 0;
    bit          manual = 0;
    int          force_wait = -1;
    int          total_waits = 0;
    bit          resp_active = 0;
    bit          resp_pend = 0;
    int          resp_waits = 0;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Registered outputs must match the model on every cycle once out of reset.
    always @(negedge clk) begin
        if (cmp_en) begin
            check_output("rdata_out", rdata_out, exp_rdata);
            check_output("pc_out", pc_out, exp_pc);
            check_output("imm_out", imm_out, exp_imm);
            check_output("control_signals_out", control_signals_out, exp_ctrl);
        end
    end

    // Bus slave: completes acked transfers, checks the request against the expected queue.
    always @(posedge clk) begin
        #3;
        if (!manual) begin
            if (resp_pend) begin
                if (exp_q.size() > 0) begin
                    if (exp_q[0].we) mem[exp_q[0].addr] = exp_q[0].data;
                    void'(exp_q.pop_front());
                end
                resp_pend   = 0;
                resp_active = 0;
            end
            if (bus_req) begin
                if (exp_q.size() == 0) begin
                    check_output("bus_req_idle", bus_req, 0);
                    bus_ack = 1'b0;
                end else begin
                    check_output("bus_we", bus_we, exp_q[0].we);
                    check_output("bus_addr", bus_addr, exp_q[0].addr);
                    if (exp_q[0].we) check_output("bus_wdata", bus_wdata, exp_q[0].data);
                    if (!resp_active) begin
                        resp_active = 1;
                        resp_waits  = (force_wait >= 0) ? force_wait : $urandom_range(0, 3);
                        total_waits += resp_waits;
                    end
                    if (resp_waits == 0) begin
                        bus_ack   = 1'b1;
                        bus_rdata = mem[bus_addr];
                        resp_pend = 1;
                    end else begin
                        resp_waits--;
                        bus_ack   = 1'b0;
                        bus_rdata = 8'($urandom);
                    end
                end
            end else begin
                bus_ack   = ($urandom_range(0, 3) == 0);
                bus_rdata = 8'($urandom);
            end
        end
    end

    task automatic apply_stimulus(input logic [32:0] ctrl, input logic [15:0] pc, input logic [15:0] imm,
                                  input logic [15:0] addr, input logic [15:0] wdata,
                                  input logic rw, input logic rb, input logic ww, input logic wb,
                                  input int hold, input bit rand_en, output int stall_cnt);
        int          nbytes;
        logic        we;
        logic [15:0] new_rdata;
        logic [15:0] a;
        bit          loaded;
        int          holds;
        int          exp_stall;

        nbytes = 0;
        we     = 1'b0;
        if (rw)      begin nbytes = 2; we = 1'b0; end
        else if (rb) begin nbytes = 1; we = 1'b0; end
        else if (ww) begin nbytes = 2; we = 1'b1; end
        else if (wb) begin nbytes = 1; we = 1'b1; end
        for (int i = 0; i < nbytes; i++) begin
            txn_t t;
            a = addr + 16'(i);
            t.we   = we;
            t.addr = a;
            t.data = (i == 0) ? wdata[7:0] : wdata[15:8];
            exp_q.push_back(t);
        end
        a = addr + 16'd1;
        if (rw)      new_rdata = {mem[a], mem[addr]};
        else if (rb) new_rdata = {8'h00, mem[addr]};
        else         new_rdata = exp_rdata;
        total_waits = 0;

        control_signals_in = ctrl;
        pc_in = pc; imm_in = imm; addr_in = addr; wdata_in = wdata;
        mem_read_w = rw; mem_read_b = rb; mem_write_w = ww; mem_write_b = wb;

        loaded = 0; holds = 0; stall_cnt = 0;
        for (int it = 0; it < 200 && !loaded; it++) begin
            en = 1'b1;
            #1;
            if (stall && rand_en) begin
                en = 1'($urandom_range(0, 1));
            end else if (!stall && holds < hold) begin
                en = 1'b0;
                holds++;
            end
            @(negedge clk);
            if (stall) stall_cnt++;
            else if (en) loaded = 1;
            @(posedge clk);
            #1;
        end
        check_output("load_timeout", loaded, 1);
        if (loaded) begin
            exp_ctrl  = ctrl;
            exp_pc    = pc;
            exp_imm   = imm;
            exp_rdata = new_rdata;
        end
        exp_stall = (nbytes == 0) ? 0 : 1 + nbytes + total_waits;
        check_output("stall_cycles", stall_cnt, exp_stall);
    endtask

    initial begin
        int sc;
        rst_n = 1'b0; en = 1'b0;
        control_signals_in = '0; pc_in = '0; imm_in = '0; addr_in = '0; wdata_in = '0;
        mem_read_b = 0; mem_read_w = 0; mem_write_b = 0; mem_write_w = 0;
        bus_ack = 1'b0; bus_rdata = 8'h00;
        exp_rdata = '0; exp_pc = '0; exp_imm = '0; exp_ctrl = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h00FE] = 8'hCD;
        mem[16'h00FF] = 8'hAB;
        mem[16'h0010] = 8'h80;

        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        cmp_en = 1;
        check_output("reset_bus_req", bus_req, 0);
        check_output("reset_bus_we", bus_we, 0);
        check_output("reset_bus_addr", bus_addr, 0);
        check_output("reset_bus_wdata", bus_wdata, 0);
        check_output("reset_stall", stall, 0);
        check_output("reset_rdata", rdata_out, 0);

        force_wait = 0;
        apply_stimulus(33'h1_0000_0001, 16'h1234, 16'h0042, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, sc);
        check_output("nop_pc", pc_out, 16'h1234);
        check_output("nop_stall", sc, 0);

        apply_stimulus(33'h0_0000_0002, 16'h0002, 16'h0003, 16'h00FE, 16'h0000, 1, 0, 0, 0, 0, 0, sc);
        check_output("read_w_data", rdata_out, 16'hABCD);
        check_output("read_w_stall", sc, 3);

        force_wait = 2;
        apply_stimulus(33'h0_0000_0003, 16'h0004, 16'h0005, 16'hFFFF, 16'h5A3C, 0, 0, 1, 0, 0, 0, sc);
        check_output("write_w_lo_byte", mem[16'hFFFF], 8'h3C);
        check_output("write_w_hi_byte", mem[16'h0000], 8'h5A);
        check_output("write_w_stall", sc, 7);
        check_output("write_keeps_rdata", rdata_out, 16'hABCD);

        force_wait = 0;
        apply_stimulus(33'h0_0000_0004, 16'h0006, 16'h0007, 16'h0010, 16'h0000, 0, 1, 0, 0, 0, 0, sc);
        check_output("read_b_data", rdata_out, 16'h0080);
        check_output("read_b_stall", sc, 2);

        apply_stimulus(33'h1_FFFF_FFFF, 16'h0008, 16'h0009, 16'h0010, 16'hFFFF, 0, 1, 1, 0, 3, 0, sc);
        check_output("read_prio_data", rdata_out, 16'h0080);
        check_output("read_prio_stall", sc, 2);
        check_output("read_prio_pc", pc_out, 16'h0008);

        force_wait = -1;
        for (int n = 0; n < 150; n++) begin
            logic [3:0]  f;
            logic [15:0] ad;
            f  = 4'($urandom);
            f  = (n % 5 == 0) ? 4'b0000 : f;
            ad = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            apply_stimulus({1'($urandom), 32'($urandom)}, 16'($urandom), 16'($urandom), ad,
                           16'($urandom), f[3], f[2], f[1], f[0], $urandom_range(0, 2), 1, sc);
        end

        manual = 1;
        bus_ack = 1'b0;
        control_signals_in = 33'h0_DEAD_0000; pc_in = 16'hBEEF; imm_in = 16'h1111;
        addr_in = 16'h0200; wdata_in = 16'h0000;
        mem_read_w = 1; mem_read_b = 0; mem_write_w = 0; mem_write_b = 0;
        en = 1'b1;
        @(posedge clk); #1;
        check_output("rst_lo_req", bus_req, 1);
        bus_ack = 1'b1; bus_rdata = 8'h11;
        @(posedge clk); #1;
        check_output("rst_hi_addr", bus_addr, 16'h0201);
        bus_ack = 1'b1; bus_rdata = 8'h22;
        rst_n = 1'b0; en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; bus_ack = 1'b0;
        exp_rdata = '0; exp_pc = '0; exp_imm = '0; exp_ctrl = '0;
        mem_read_w = 0;
        check_output("rst_mid_bus_req", bus_req, 0);
        check_output("rst_mid_bus_addr", bus_addr, 0);
        check_output("rst_mid_stall", stall, 0);
        check_output("rst_mid_rdata", rdata_out, 0);
        check_output("rst_mid_pc", pc_out, 0);
        exp_q.delete();
        resp_pend = 0; resp_active = 0;
        manual = 0;
        apply_stimulus(33'h0_0000_0077, 16'h4321, 16'h0001, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, sc);
        check_output("post_rst_pc", pc_out, 16'h4321);
        check_output("post_rst_rdata", rdata_out, 0);

        en = 1'b0;
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
